// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler
// Sequences bytes for an SPI-attached LCD controller.
//   - Serves single command bytes from a requester while idle.
//   - Streams full frames: CASET/PASET/RAMWR window setup, then RGB565
//     pixels as two data bytes each (MSB first).
// A downstream byte engine does the actual serialisation. This block issues one
// byte at a time with spi_start, then waits for spi_done.
//
// Optional build macro: LCD_SCHED_TIMEOUT_EN
//   Adds a pixel-starvation watchdog in WAIT_PIX. When it expires, the block
//   aborts the frame and re-sends the window. Without the macro, timeout is a
//   constant 0 and no idle counter exists.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | nothing in flight; commands win over frame start
// CMD      | send the latched command byte, ack on completion
// WIN      | send the 11-byte address window + RAMWR sequence
// WAIT_PIX | pix_ready high, waiting for the next pixel
// PIX_HI   | send latched pixel bits [15:8]
// PIX_LO   | send latched pixel bits [7:0], then count the pixel

module lcd_frame_scheduler #(
    parameter int H_MAX        = 239,
    parameter int V_MAX        = 319,
    parameter int IDLE_TIMEOUT = 5_000_000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        frame_en,
    input  logic        cmd_req,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_dc,
    output logic        cmd_ack,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        spi_start,
    output logic [7:0]  spi_byte,
    output logic        spi_dc,
    input  logic        spi_busy,
    input  logic        spi_done,
    output logic        frame_done,
    output logic        timeout
);

    localparam int TOTAL_PIX = (H_MAX + 1) * (V_MAX + 1);
    // At least 17 bits, so the default 320x240 frame fits without wrap.
    localparam int PCW = ($clog2(TOTAL_PIX) > 17) ? $clog2(TOTAL_PIX) : 17;
    localparam logic [PCW-1:0] LAST_PIX = PCW'(TOTAL_PIX - 1);
    localparam logic [15:0]    H_MAX16  = 16'(H_MAX);
    localparam logic [15:0]    V_MAX16  = 16'(V_MAX);
    localparam logic [3:0]     WIN_LAST = 4'd10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WIN      = 3'd2,
        WAIT_PIX = 3'd3,
        PIX_HI   = 3'd4,
        PIX_LO   = 3'd5
    } state_t;

    state_t          state_q;
    logic            sent_q;        // byte of the current step handed to the engine
    logic [3:0]      win_step_q;
    logic [PCW-1:0]  pixel_cnt_q;
    logic [15:0]     pix_q;
    logic [7:0]      cmd_byte_q;
    logic            cmd_dc_q;

    logic            spi_start_q;
    logic [7:0]      spi_byte_q;
    logic            spi_dc_q;
    logic            pix_ready_q;
    logic            cmd_ack_q;
    logic            frame_done_q;

    logic [7:0]      byte_d;
    logic            dc_d;

`ifdef LCD_SCHED_TIMEOUT_EN
    localparam int IW = $clog2(IDLE_TIMEOUT + 1) + 1;
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(IDLE_TIMEOUT);
    logic [IW-1:0]   idle_q;
    logic            timeout_q;
`endif

    // Byte and D/C that the current issuing state wants to send next.
    always_comb begin
        byte_d = 8'h00;
        dc_d   = 1'b1;
        case (state_q)
            CMD: begin
                byte_d = cmd_byte_q;
                dc_d   = cmd_dc_q;
            end
            WIN: begin
                case (win_step_q)
                    4'd0:    begin byte_d = 8'h2A;         dc_d = 1'b0; end
                    4'd1:    begin byte_d = 8'h00;         dc_d = 1'b1; end
                    4'd2:    begin byte_d = 8'h00;         dc_d = 1'b1; end
                    4'd3:    begin byte_d = H_MAX16[15:8]; dc_d = 1'b1; end
                    4'd4:    begin byte_d = H_MAX16[7:0];  dc_d = 1'b1; end
                    4'd5:    begin byte_d = 8'h2B;         dc_d = 1'b0; end
                    4'd6:    begin byte_d = 8'h00;         dc_d = 1'b1; end
                    4'd7:    begin byte_d = 8'h00;         dc_d = 1'b1; end
                    4'd8:    begin byte_d = V_MAX16[15:8]; dc_d = 1'b1; end
                    4'd9:    begin byte_d = V_MAX16[7:0];  dc_d = 1'b1; end
                    default: begin byte_d = 8'h2C;         dc_d = 1'b0; end
                endcase
            end
            PIX_HI: begin
                byte_d = pix_q[15:8];
                dc_d   = 1'b1;
            end
            PIX_LO: begin
                byte_d = pix_q[7:0];
                dc_d   = 1'b1;
            end
            default: begin
                byte_d = 8'h00;
                dc_d   = 1'b1;
            end
        endcase
    end

    // Main sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q      <= IDLE;
            sent_q       <= 1'b0;
            win_step_q   <= 4'd0;
            pixel_cnt_q  <= '0;
            pix_q        <= 16'h0000;
            cmd_byte_q   <= 8'h00;
            cmd_dc_q     <= 1'b0;
            spi_start_q  <= 1'b0;
            spi_byte_q   <= 8'h00;
            spi_dc_q     <= 1'b0;
            pix_ready_q  <= 1'b0;
            cmd_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef LCD_SCHED_TIMEOUT_EN
            idle_q       <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; they are raised for one cycle below.
            spi_start_q  <= 1'b0;
            cmd_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef LCD_SCHED_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    sent_q <= 1'b0;
                    if (cmd_req) begin
                        cmd_byte_q <= cmd_byte;
                        cmd_dc_q   <= cmd_dc;
                        state_q    <= CMD;
                    end else if (frame_en) begin
                        win_step_q <= 4'd0;
                        state_q    <= WIN;
                    end
                end

                CMD, WIN, PIX_HI, PIX_LO: begin
                    if (!sent_q) begin
                        if (!spi_busy) begin
                            spi_start_q <= 1'b1;
                            spi_byte_q  <= byte_d;
                            spi_dc_q    <= dc_d;
                            sent_q      <= 1'b1;
                        end
                    end else if (spi_done) begin
                        sent_q <= 1'b0;
                        case (state_q)
                            CMD: begin
                                cmd_ack_q <= 1'b1;
                                state_q   <= IDLE;
                            end
                            WIN: begin
                                if (win_step_q == WIN_LAST) begin
                                    win_step_q  <= 4'd0;
                                    pixel_cnt_q <= '0;
`ifdef LCD_SCHED_TIMEOUT_EN
                                    idle_q      <= '0;
`endif
                                    pix_ready_q <= 1'b1;
                                    state_q     <= WAIT_PIX;
                                end else begin
                                    win_step_q <= win_step_q + 4'd1;
                                end
                            end
                            PIX_HI: begin
                                state_q <= PIX_LO;
                            end
                            PIX_LO: begin
                                if (pixel_cnt_q == LAST_PIX) begin
                                    frame_done_q <= 1'b1;
                                    pixel_cnt_q  <= '0;
                                    state_q      <= IDLE;
                                end else begin
                                    pixel_cnt_q <= pixel_cnt_q + PCW'(1);
                                    pix_ready_q <= 1'b1;
                                    state_q     <= WAIT_PIX;
                                end
                            end
                            default: begin
                                state_q <= IDLE;
                            end
                        endcase
                    end
                end

                WAIT_PIX: begin
                    if (pix_valid && pix_ready_q) begin
                        pix_q       <= pix_data;
                        pix_ready_q <= 1'b0;
                        state_q     <= PIX_HI;
`ifdef LCD_SCHED_TIMEOUT_EN
                        idle_q      <= '0;
                    end else if (idle_q == IDLE_LIMIT) begin
                        // Starved too long: drop the partial frame and re-send the window.
                        timeout_q   <= 1'b1;
                        idle_q      <= '0;
                        pixel_cnt_q <= '0;
                        win_step_q  <= 4'd0;
                        pix_ready_q <= 1'b0;
                        state_q     <= WIN;
                    end else begin
                        idle_q <= idle_q + IW'(1);
`endif
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    sent_q      <= 1'b0;
                    pix_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign spi_start  = spi_start_q;
    assign spi_byte   = spi_byte_q;
    assign spi_dc     = spi_dc_q;
    assign pix_ready  = pix_ready_q;
    assign cmd_ack    = cmd_ack_q;
    assign frame_done = frame_done_q;

`ifdef LCD_SCHED_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // Watchdog not built: constant 0, the parameter is only referenced here.
    assign timeout = (IDLE_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
`timescale 1ns/1ps
module tb_lcd_frame_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [7:0] b; logic dc; } win_vec_t;
    typedef struct { logic [15:0] pix; logic [7:0] exp_hi; logic [7:0] exp_lo; } pix_vec_t;

    win_vec_t d_win [11];
    win_vec_t s_win [11];
    pix_vec_t pix_tab [8];

    // ---------------- default-parameter instance (d_) ----------------
    logic        d_rst = 1'b1, d_frame_en = 1'b0, d_cmd_req = 1'b0, d_cmd_dc = 1'b0;
    logic [7:0]  d_cmd_byte = 8'h00;
    logic        d_pix_valid = 1'b0;
    logic [15:0] d_pix_data = 16'h0000;
    logic        d_busy = 1'b0, d_done = 1'b0;
    logic        d_cmd_ack, d_pix_ready, d_spi_start, d_spi_dc, d_frame_done, d_timeout;
    logic [7:0]  d_spi_byte;

    // ---------------- small-frame instance (s_): 4x2 pixels ----------------
    logic        s_rst = 1'b1, s_frame_en = 1'b0, s_cmd_req = 1'b0, s_cmd_dc = 1'b0;
    logic [7:0]  s_cmd_byte = 8'h00;
    logic        s_pix_valid = 1'b0;
    logic [15:0] s_pix_data = 16'h0000;
    logic        s_busy = 1'b0, s_done = 1'b0;
    logic        s_cmd_ack, s_pix_ready, s_spi_start, s_spi_dc, s_frame_done, s_timeout;
    logic [7:0]  s_spi_byte;

    lcd_frame_scheduler dut_d (
        .clk(clk), .reset_p(d_rst), .frame_en(d_frame_en),
        .cmd_req(d_cmd_req), .cmd_byte(d_cmd_byte), .cmd_dc(d_cmd_dc), .cmd_ack(d_cmd_ack),
        .pix_valid(d_pix_valid), .pix_data(d_pix_data), .pix_ready(d_pix_ready),
        .spi_start(d_spi_start), .spi_byte(d_spi_byte), .spi_dc(d_spi_dc),
        .spi_busy(d_busy), .spi_done(d_done),
        .frame_done(d_frame_done), .timeout(d_timeout)
    );

    lcd_frame_scheduler #(.H_MAX(3), .V_MAX(1), .IDLE_TIMEOUT(1000)) dut_s (
        .clk(clk), .reset_p(s_rst), .frame_en(s_frame_en),
        .cmd_req(s_cmd_req), .cmd_byte(s_cmd_byte), .cmd_dc(s_cmd_dc), .cmd_ack(s_cmd_ack),
        .pix_valid(s_pix_valid), .pix_data(s_pix_data), .pix_ready(s_pix_ready),
        .spi_start(s_spi_start), .spi_byte(s_spi_byte), .spi_dc(s_spi_dc),
        .spi_busy(s_busy), .spi_done(s_done),
        .frame_done(s_frame_done), .timeout(s_timeout)
    );

    // Byte-engine models: log each started byte, answer with spi_done after a latency.
    logic [8:0] d_log [$];
    logic [8:0] s_log [$];
    int d_ph = 0, d_cnt = 0, d_lat = 0, d_viol = 0;
    logic d_hold = 1'b0;
    int s_ph = 0, s_viol = 0;
    int s_cyc = 0, s_fd_cnt = 0, s_fd_cyc = 0, s_fd_logsz = 0;
    int s_ack_cnt = 0, s_ack_cyc = 0, s_ack_logsz = 0, s_to_cnt = 0;

    always @(negedge clk) begin
        if (d_spi_start === 1'b1 && d_busy) d_viol++;
        if (d_hold) begin
            d_busy = 1'b1;
            d_done = 1'b0;
        end else if (d_ph == 0) begin
            d_busy = 1'b0;
            d_done = 1'b0;
            if (d_spi_start === 1'b1) begin
                d_log.push_back({d_spi_dc, d_spi_byte});
                d_ph = 1; d_cnt = d_lat; d_busy = 1'b1;
            end
        end else if (d_ph == 1) begin
            if (d_cnt == 0) begin d_done = 1'b1; d_ph = 2; end
            else d_cnt--;
        end else begin
            d_done = 1'b0; d_busy = 1'b0; d_ph = 0;
        end
    end

    always @(negedge clk) begin
        s_cyc++;
        if (s_spi_start === 1'b1 && s_busy) s_viol++;
        if (s_ph == 0) begin
            s_busy = 1'b0;
            s_done = 1'b0;
            if (s_spi_start === 1'b1) begin
                s_log.push_back({s_spi_dc, s_spi_byte});
                s_ph = 1; s_busy = 1'b1;
            end
        end else if (s_ph == 1) begin
            s_done = 1'b1; s_ph = 2;
        end else begin
            s_done = 1'b0; s_busy = 1'b0; s_ph = 0;
        end
        if (s_frame_done === 1'b1) begin s_fd_cnt++; s_fd_cyc = s_cyc; s_fd_logsz = s_log.size(); end
        if (s_cmd_ack === 1'b1)    begin s_ack_cnt++; s_ack_cyc = s_cyc; s_ack_logsz = s_log.size(); end
        if (s_timeout === 1'b1)    s_to_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_d_log(input string name, input int need, input int budget);
        int n = 0;
        while (d_log.size() < need && n < budget) begin tick(); n++; end
        check(name, (d_log.size() >= need), 1);
    endtask

    task automatic wait_s_log(input string name, input int need, input int budget);
        int n = 0;
        while (s_log.size() < need && n < budget) begin tick(); n++; end
        check(name, (s_log.size() >= need), 1);
    endtask

    task automatic check_s_window(input string tag, input int base);
        for (int i = 0; i < 11; i++)
            check($sformatf("%s_win%0d", tag, i), s_log[base + i], {s_win[i].dc, s_win[i].b});
    endtask

    task automatic feed_s(input int idx);
        int n = 0;
        while (s_pix_ready !== 1'b1 && n < 200) begin tick(); n++; end
        check($sformatf("s_ready_wait%0d", idx), s_pix_ready, 1);
        s_pix_data  = pix_tab[idx].pix;
        s_pix_valid = 1'b1;
        tick();
        s_pix_valid = 1'b0;
        check($sformatf("s_ready_drop%0d", idx), s_pix_ready, 0);
    endtask

    task automatic check_s_pixels(input string tag, input int base);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_hi%0d", tag, i), s_log[base + 2*i],     {1'b1, pix_tab[i].exp_hi});
            check($sformatf("%s_lo%0d", tag, i), s_log[base + 2*i + 1], {1'b1, pix_tab[i].exp_lo});
        end
    endtask

    initial begin
        int n, cnt, base, base2, stray;

        d_win[0]  = '{8'h2A, 1'b0}; d_win[1]  = '{8'h00, 1'b1}; d_win[2]  = '{8'h00, 1'b1};
        d_win[3]  = '{8'h00, 1'b1}; d_win[4]  = '{8'hEF, 1'b1}; d_win[5]  = '{8'h2B, 1'b0};
        d_win[6]  = '{8'h00, 1'b1}; d_win[7]  = '{8'h00, 1'b1}; d_win[8]  = '{8'h01, 1'b1};
        d_win[9]  = '{8'h3F, 1'b1}; d_win[10] = '{8'h2C, 1'b0};

        s_win[0]  = '{8'h2A, 1'b0}; s_win[1]  = '{8'h00, 1'b1}; s_win[2]  = '{8'h00, 1'b1};
        s_win[3]  = '{8'h00, 1'b1}; s_win[4]  = '{8'h03, 1'b1}; s_win[5]  = '{8'h2B, 1'b0};
        s_win[6]  = '{8'h00, 1'b1}; s_win[7]  = '{8'h00, 1'b1}; s_win[8]  = '{8'h00, 1'b1};
        s_win[9]  = '{8'h01, 1'b1}; s_win[10] = '{8'h2C, 1'b0};

        pix_tab[0] = '{16'hF800, 8'hF8, 8'h00};
        pix_tab[1] = '{16'hF800, 8'hF8, 8'h00};
        pix_tab[2] = '{16'h07E0, 8'h07, 8'hE0};
        pix_tab[3] = '{16'h001F, 8'h00, 8'h1F};
        pix_tab[4] = '{16'hFFFF, 8'hFF, 8'hFF};
        pix_tab[5] = '{16'h0000, 8'h00, 8'h00};
        pix_tab[6] = '{16'hA55A, 8'hA5, 8'h5A};
        pix_tab[7] = '{16'h8001, 8'h80, 8'h01};

        // ---------- reset state ----------
        repeat (3) tick();
        check("d_rst_spi_start", d_spi_start, 0);
        check("d_rst_spi_byte", d_spi_byte, 0);
        check("d_rst_spi_dc", d_spi_dc, 0);
        check("d_rst_pix_ready", d_pix_ready, 0);
        check("d_rst_cmd_ack", d_cmd_ack, 0);
        check("d_rst_frame_done", d_frame_done, 0);
        check("d_rst_timeout", d_timeout, 0);
        check("s_rst_pix_ready", s_pix_ready, 0);
        check("s_rst_spi_byte", s_spi_byte, 0);
        d_rst = 1'b0;
        s_rst = 1'b0;
        tick();
        check("d_idle_no_start", d_spi_start, 0);

        // ---------- default window sequence ----------
        d_frame_en = 1'b1;
        wait_d_log("d_win_wait", 11, 400);
        d_frame_en = 1'b0;
        for (int i = 0; i < 11; i++)
            check($sformatf("d_win%0d", i), d_log[i], {d_win[i].dc, d_win[i].b});
        n = 0;
        while (d_pix_ready !== 1'b1 && n < 50) begin tick(); n++; end
        check("d_ready_after_win", d_pix_ready, 1);

        // ---------- busy engine holds off spi_start ----------
        d_hold = 1'b1;
        d_pix_data  = 16'h1234;
        d_pix_valid = 1'b1;
        tick();
        d_pix_valid = 1'b0;
        check("d_ready_drop", d_pix_ready, 0);
        cnt = 0;
        repeat (50) begin tick(); if (d_spi_start) cnt++; end
        check("d_start_while_busy", cnt, 0);
        check("d_log_during_busy", d_log.size(), 11);
        d_hold = 1'b0;
        wait_d_log("d_hi_wait", 12, 50);
        check("d_pix_hi", d_log[11], {1'b1, 8'h12});
        d_lat = 3;
        wait_d_log("d_lo_wait", 13, 50);
        check("d_pix_lo", d_log[12], {1'b1, 8'h34});

        // ---------- reset mid-PIX_LO, then a stray spi_done ----------
        d_rst = 1'b1;
        tick();
        check("d_mid_rst_spi_start", d_spi_start, 0);
        check("d_mid_rst_spi_byte", d_spi_byte, 0);
        check("d_mid_rst_spi_dc", d_spi_dc, 0);
        check("d_mid_rst_pix_ready", d_pix_ready, 0);
        check("d_mid_rst_cmd_ack", d_cmd_ack, 0);
        check("d_mid_rst_frame_done", d_frame_done, 0);
        check("d_mid_rst_timeout", d_timeout, 0);
        d_rst = 1'b0;
        d_lat = 0;
        cnt = 0;
        stray = 0;
        repeat (10) begin
            tick();
            if (d_done) stray++;
            if (d_spi_start || d_pix_ready || d_cmd_ack || d_frame_done) cnt++;
        end
        check("d_stray_done_seen", stray, 1);
        check("d_stray_no_activity", cnt, 0);
        check("d_stray_no_bytes", d_log.size(), 13);
        d_frame_en = 1'b1;
        wait_d_log("d_restart_wait", 14, 50);
        d_frame_en = 1'b0;
        check("d_restart_2A", d_log[13], {1'b0, 8'h2A});

        // ---------- small frame, command held off to frame end ----------
        s_frame_en = 1'b1;
        wait_s_log("s_win_wait", 11, 400);
        check_s_window("s1", 0);
        for (int i = 0; i < 8; i++) begin
            feed_s(i);
            if (i == 1) s_frame_en = 1'b0;
            if (i == 3) begin s_cmd_byte = 8'h36; s_cmd_dc = 1'b0; s_cmd_req = 1'b1; end
        end
        n = 0;
        while (s_cmd_ack !== 1'b1 && n < 200) begin tick(); n++; end
        s_cmd_req = 1'b0;
        check("s_ack_seen", s_cmd_ack, 1);
        repeat (10) tick();
        check_s_pixels("s1", 11);
        check("s_fd_count", s_fd_cnt, 1);
        check("s_fd_after_last_byte", s_fd_logsz, 27);
        check("s_cmd_first_after_frame", s_log[27], {1'b0, 8'h36});
        check("s_ack_count", s_ack_cnt, 1);
        check("s_ack_logsz", s_ack_logsz, 28);
        check("s_ack_after_fd", (s_ack_cyc > s_fd_cyc), 1);
        check("s_idle_after_cmd", s_log.size(), 28);

        // ---------- starvation after 5 pixels ----------
        base = s_log.size();
        s_frame_en = 1'b1;
        wait_s_log("s_win2_wait", base + 11, 400);
        s_frame_en = 1'b0;
        check_s_window("s2", base);
        for (int i = 0; i < 5; i++) feed_s(i);
        n = 0;
        while (s_pix_ready !== 1'b1 && n < 50) begin tick(); n++; end
        check("s_ready_before_starve", s_pix_ready, 1);
`ifdef LCD_SCHED_TIMEOUT_EN
        n = 0;
        do begin tick(); n++; end while (s_timeout !== 1'b1 && n < 2000);
        check("s_timeout_cycles", n, 1001);
        tick();
        check("s_timeout_one_cycle", s_timeout, 0);
        base2 = base + 11 + 10;
        wait_s_log("s_resync_wait", base2 + 11, 400);
        check_s_window("s3", base2);
        for (int i = 0; i < 8; i++) feed_s(i);
        n = 0;
        while (s_fd_cnt < 2 && n < 200) begin tick(); n++; end
        check("s_fd_count2", s_fd_cnt, 2);
        check("s_fd_after_resync", s_fd_logsz, base2 + 11 + 16);
        check_s_pixels("s3", base2 + 11);
        check("s_timeout_count", s_to_cnt, 1);
`else
        repeat (1100) tick();
        check("s_no_timeout", s_to_cnt, 0);
        check("s_still_ready", s_pix_ready, 1);
        check("s_no_bytes_while_starved", s_log.size(), base + 11 + 10);
        for (int i = 5; i < 8; i++) feed_s(i);
        n = 0;
        while (s_fd_cnt < 2 && n < 200) begin tick(); n++; end
        check("s_fd_count2", s_fd_cnt, 2);
        check("s_fd_after_wait", s_fd_logsz, base + 11 + 16);
        check_s_pixels("s2", base + 11);
`endif

        check("d_start_busy_overlap", d_viol, 0);
        check("s_start_busy_overlap", s_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_frame_scheduler.md
LCD_FRAME_SCHEDULER -- requirements
Module: lcd_frame_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: ports clk and reset_p.
REQ-002 The block SHALL have parameter H_MAX, default 239, last column index written to the CASET window.
REQ-003 The block SHALL have parameter V_MAX, default 319, last row index written to the PASET window.
REQ-004 The block SHALL have parameter IDLE_TIMEOUT, default 5_000_000, the pixel-starvation timeout in clk cycles.
REQ-005 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  system clock, 100 MHz
  reset_p  in  1  synchronous active-high reset
  frame_en  in  1  allow frame streaming
  cmd_req  in  1  command requester wants one byte sent
  cmd_byte  in  8  command-port byte
  cmd_dc  in  1  D/C level for cmd_byte
  cmd_ack  out  1  one-cycle pulse: command byte finished on SPI
  pix_valid  in  1  RGB565 pixel available
  pix_data  in  16  RGB565 pixel, MSB byte sent first
  pix_ready  out  1  scheduler accepts a pixel this cycle
  spi_start  out  1  one-cycle pulse: byte engine starts spi_byte
  spi_byte  out  8  byte to serialize, held stable until spi_done
  spi_dc  out  1  D/C for spi_byte, held stable until spi_done
  spi_busy  in  1  byte engine busy
  spi_done  in  1  one-cycle pulse: byte fully shifted out
  frame_done  out  1  one-cycle pulse after the last pixel low byte
  timeout  out  1  one-cycle pulse on a pixel-starvation abort

Function
REQ-006 States SHALL be IDLE, CMD, WIN, WAIT_PIX, PIX_HI, PIX_LO; every SPI-issuing state SHALL assert spi_start only when spi_busy=0, then wait for spi_done before advancing.
REQ-007 IDLE: if cmd_req=1, the block SHALL go to CMD (command priority); else if frame_en=1, it SHALL go to WIN with win_step=0; else it SHALL stay in IDLE.
REQ-008 CMD: the block SHALL latch cmd_byte/cmd_dc on entry, send one byte, pulse cmd_ack in the spi_done cycle, and return to IDLE.
REQ-009 WIN: the block SHALL send 11 bytes in this order: 2A(dc0), 00, 00, H_MAX[15:8], H_MAX[7:0] (dc1), 2B(dc0), 00, 00, V_MAX[15:8], V_MAX[7:0] (dc1), 2C(dc0); it SHALL then clear pixel_cnt and the idle counter and go to WAIT_PIX.
REQ-010 WAIT_PIX: pix_ready SHALL be 1 only in this state; when pix_valid=1 and pix_ready=1, the block SHALL latch pix_data and go to PIX_HI.
REQ-011 PIX_HI SHALL send pix_data[15:8] with dc1, then go to PIX_LO; PIX_LO SHALL send pix_data[7:0] with dc1.
REQ-012 After the PIX_LO spi_done: if pixel_cnt == (H_MAX+1)*(V_MAX+1)-1 (76799 by default), the block SHALL pulse frame_done, clear pixel_cnt, and go to IDLE; otherwise it SHALL increment pixel_cnt and return to WAIT_PIX.
REQ-013 pixel_cnt SHALL be 17 bits wide minimum; it SHALL never wrap, because the terminal count forces the return to IDLE.
REQ-014 cmd_req asserted during WIN, WAIT_PIX, PIX_HI or PIX_LO SHALL be held off and served only at the next IDLE (frame boundary).
REQ-015 spi_start SHALL rise at most one cycle after entering an issuing state whose spi_busy=0; it SHALL never be asserted while spi_busy=1.
REQ-016 spi_done received in IDLE or WAIT_PIX SHALL be ignored.
REQ-017 frame_en deasserted mid-frame SHALL NOT abort the frame; it SHALL only gate the next IDLE→WIN transition.

Reset
REQ-018 On reset_p=1 at a clk edge, the block SHALL enter IDLE and set all outputs and counters to 0: spi_start, spi_byte, spi_dc, pix_ready, cmd_ack, frame_done, timeout, pixel_cnt, win_step, and the idle counter.
REQ-019 A reset asserted mid-byte SHALL abandon the byte; a late spi_done after reset SHALL be ignored per REQ-016.

Configuration
REQ-020 With macro LCD_SCHED_TIMEOUT_EN defined, the idle counter in WAIT_PIX SHALL count cycles with pix_valid=0; on exceeding IDLE_TIMEOUT, the block SHALL pulse timeout, clear pixel_cnt, and go to WIN (window re-sync).
REQ-021 Without LCD_SCHED_TIMEOUT_EN, WAIT_PIX SHALL wait indefinitely, timeout SHALL be tied to 0, and no idle counter SHALL be synthesized.

Verification
REQ-022 Reset, then frame_en=1 with an ideal engine: spi_byte sequence SHALL be exactly 2A,00,00,00,EF,2B,00,00,01,3F,2C with dc 0,1,1,1,1,0,1,1,1,1,0.
REQ-023 Stream 76800 pixels of 16'hF800: the bench SHALL observe 153600 data bytes alternating F8,00, then exactly one frame_done pulse, then the state returns to IDLE.
REQ-024 cmd_req=1 (cmd_byte=36, dc0) raised at pixel 100: cmd_ack SHALL NOT fire until after frame_done, and byte 36 SHALL be the first byte sent after the frame.
REQ-025 With LCD_SCHED_TIMEOUT_EN defined and IDLE_TIMEOUT=1000, stop pix_valid after 5 pixels: timeout SHALL pulse once after 1001 idle cycles, and the next bytes SHALL be 2A... with pixel_cnt=0.
REQ-026 Hold spi_busy=1 for 50 cycles: spi_start SHALL stay 0 until spi_busy falls; then assert reset_p mid-PIX_LO: all outputs SHALL be 0 on the next cycle, and a stray spi_done SHALL cause no state change.
